fp_mul_normalize: RTL and testbench

Post-multiply normalise/round stage of the floating-point multiplier. It sits directly downstream of `unsigned_mul` and consumes its 2·MW-bit mantissa product `R`, along with the operand sign and biased exponents, to produce a packed IEEE-754 result. It is a 2-stage valid/ready pipeline: stage 1 normalises, stage 2 rounds and packs, with overflow/underflow flags.

---
 rtl/fp_mul_normalize.sv | 147 ++++++++++++++
 tb/tb_fp_mul_normalize.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_normalize.sv
// fp_mul_normalize: two-stage normalise / round-and-pack stage after the mantissa multiplier.
// Define FP_MUL_ROUND_RNE_EN for round-to-nearest-even; left undefined, the fraction is truncated.
module fp_mul_normalize #(
  parameter int MW   = 24,
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EW-1:0]    in_exp_a,
  input  logic [EW-1:0]    in_exp_b,
  input  logic [2*MW-1:0]  in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW-1:0] out_result,
  output logic             out_ovf,
  output logic             out_unf
);
  localparam int XW = EW + 2;
  localparam int FW = MW - 1;
  localparam int RW = EW + MW;
  localparam logic signed [XW-1:0] E_MAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] E_ZERO = '0;
  localparam logic signed [XW-1:0] E_BIAS = XW'(BIAS);

`ifdef FP_MUL_ROUND_RNE_EN
  // Returns {carry, fraction}; a carry means the significand rolled over to 2.0.
  function automatic logic [FW:0] round_rne(input logic [FW-1:0] f, input logic g,
                                            input logic s);
    logic inc;
    inc = g & (s | f[0]);
    return {1'b0, f} + {{FW{1'b0}}, inc};
  endfunction
`endif

  // Returns {ovf, unf, result}; specials win over exponent range saturation.
  function automatic logic [RW+1:0] pack_sat(input logic s, input logic signed [XW-1:0] e,
                                             input logic [FW-1:0] f, input logic inf,
                                             input logic zero);
    logic [RW+1:0] r;
    if (inf)               r = {2'b00, s, {EW{1'b1}}, {FW{1'b0}}};
    else if (zero)         r = {2'b00, s, {EW{1'b0}}, {FW{1'b0}}};
    else if (e >= E_MAX)   r = {2'b10, s, {EW{1'b1}}, {FW{1'b0}}};
    else if (e <= E_ZERO)  r = {2'b01, s, {EW{1'b0}}, {FW{1'b0}}};
    else                   r = {2'b00, s, e[EW-1:0], f};
    return r;
  endfunction

  logic                 vld_p1_q, vld_p1_d;
  logic                 sign_p1_q, sign_p1_d;
  logic signed [XW-1:0] exp_p1_q, exp_p1_d;
  logic [FW-1:0]        frac_p1_q, frac_p1_d;
  logic                 zero_p1_q, zero_p1_d;
  logic                 inf_p1_q, inf_p1_d;
`ifdef FP_MUL_ROUND_RNE_EN
  logic                 guard_p1_q, guard_p1_d;
  logic                 sticky_p1_q, sticky_p1_d;
  logic [FW:0]          rnd_p2;
`endif
  logic                 out_valid_q, out_valid_d;
  logic [RW-1:0]        out_result_q, out_result_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_unf_q, out_unf_d;

  logic                 adv2, take_in, load_p2;
  logic signed [XW-1:0] exp_p0, exp_p2;
  logic [FW-1:0]        frac_p0, frac_p2;
  logic [RW+1:0]        packed_p2;

  assign adv2     = !out_valid_q || out_ready;
  assign in_ready = !vld_p1_q || adv2;
  assign take_in  = in_valid && in_ready;
  assign load_p2  = adv2 && vld_p1_q;

  // Stage 1: normalise so the leading one of the product becomes the hidden bit
  always_comb begin
    exp_p0  = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - E_BIAS
            + $signed({{(XW-1){1'b0}}, in_prod[2*MW-1]});
    frac_p0 = in_prod[2*MW-1] ? in_prod[2*MW-2 -: FW] : in_prod[2*MW-3 -: FW];

    vld_p1_d  = in_ready ? in_valid : vld_p1_q;
    sign_p1_d = take_in ? in_sign : sign_p1_q;
    exp_p1_d  = take_in ? exp_p0 : exp_p1_q;
    frac_p1_d = take_in ? frac_p0 : frac_p1_q;
    zero_p1_d = take_in ? ((in_exp_a == '0) || (in_exp_b == '0) || (in_prod == '0))
                        : zero_p1_q;
    inf_p1_d  = take_in ? ((&in_exp_a) || (&in_exp_b)) : inf_p1_q;
`ifdef FP_MUL_ROUND_RNE_EN
    guard_p1_d  = take_in ? (in_prod[2*MW-1] ? in_prod[MW-1] : in_prod[MW-2]) : guard_p1_q;
    sticky_p1_d = take_in ? (in_prod[2*MW-1] ? (|in_prod[MW-2:0]) : (|in_prod[MW-3:0]))
                          : sticky_p1_q;
`endif
  end

  // Stage 2: round, then pack with saturation into the output registers
  always_comb begin
`ifdef FP_MUL_ROUND_RNE_EN
    rnd_p2  = round_rne(frac_p1_q, guard_p1_q, sticky_p1_q);
    frac_p2 = rnd_p2[FW-1:0];
    exp_p2  = exp_p1_q + $signed({{(XW-1){1'b0}}, rnd_p2[FW]});
`else
    frac_p2 = frac_p1_q;
    exp_p2  = exp_p1_q;
`endif
    packed_p2    = pack_sat(sign_p1_q, exp_p2, frac_p2, inf_p1_q, zero_p1_q);
    out_valid_d  = adv2 ? vld_p1_q : out_valid_q;
    out_result_d = load_p2 ? packed_p2[RW-1:0] : out_result_q;
    out_ovf_d    = load_p2 ? packed_p2[RW+1] : out_ovf_q;
    out_unf_d    = load_p2 ? packed_p2[RW] : out_unf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_unf_q    <= out_unf_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q   <= sign_p1_d;
    exp_p1_q    <= exp_p1_d;
    frac_p1_q   <= frac_p1_d;
    zero_p1_q   <= zero_p1_d;
    inf_p1_q    <= inf_p1_d;
`ifdef FP_MUL_ROUND_RNE_EN
    guard_p1_q  <= guard_p1_d;
    sticky_p1_q <= sticky_p1_d;
`endif
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_unf    = out_unf_q;
endmodule

// File: tb/tb_fp_mul_normalize.sv
// Testbench for fp_mul_normalize: hand-derived vector table, backpressure and reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_fp_mul_normalize;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp_a = '0;
  logic [7:0]  in_exp_b = '0;
  logic [47:0] in_prod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  always #5 clk = ~clk;

  fp_mul_normalize #(.MW(24), .EW(8), .BIAS(127)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp_a(in_exp_a), .in_exp_b(in_exp_b), .in_prod(in_prod), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  typedef struct {
    logic        s;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] p;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          acc_cnt = 0;
  int          out_cnt = 0;
  logic [33:0] exp_q[$];
  logic        held_vld = 1'b0;
  logic [33:0] held = '0;
  vec_t        tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: significand as an integer, remainder compared against one half ulp.
  function automatic logic [33:0] model(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                                        input logic [47:0] p);
    longint unsigned pp, mant;
`ifdef FP_MUL_ROUND_RNE_EN
    longint unsigned rem, half;
`endif
    int          sh, e;
    logic [31:0] res;
    logic        ovf, unf;
    pp = 64'(p);
    ovf = 1'b0;
    unf = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) res = {s, 8'hFF, 23'h0};
    else if (ea == 8'h00 || eb == 8'h00 || pp == 0) res = {s, 31'h0};
    else begin
      sh = p[47] ? 24 : 23;
      e = int'(ea) + int'(eb) - 127 + (p[47] ? 1 : 0);
      mant = pp >> sh;
`ifdef FP_MUL_ROUND_RNE_EN
      rem = pp & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
`endif
      if (mant >= 64'h1000000) begin
        mant = mant >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0};
        ovf = 1'b1;
      end else if (e <= 0) begin
        res = {s, 31'h0};
        unf = 1'b1;
      end else res = {s, 8'(e), mant[22:0]};
    end
    return {ovf, unf, res};
  endfunction

  function automatic logic [47:0] gen_prod();
    logic [47:0] p;
    int k;
    p = {16'($urandom()), $urandom()};
    k = $urandom_range(0, 99);
    if (k < 3) return '0;
    if ($urandom_range(0, 1) == 1) p[47] = 1'b1;
    else begin
      p[47] = 1'b0;
      p[46] = 1'b1;
    end
    if (k < 25) begin
      if (p[47]) p[23:0] = 24'h800000;
      else p[22:0] = 23'h400000;
    end else if (k < 35) begin
      if (p[47]) p[46:23] = '1;
      else p[45:22] = '1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gen_exp();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hFF;
    return 8'($urandom_range(1, 254));
  endfunction

  // One clock of handshake traffic with scoreboard and hold-stability checks.
  task automatic cycle(input logic v, input logic s, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [47:0] p, input logic rdy);
    logic [33:0] got;
    @(posedge clk); #1;
    in_valid = v; in_sign = s; in_exp_a = ea; in_exp_b = eb; in_prod = p; out_ready = rdy;
    #1;
    got = {out_ovf, out_unf, out_result};
    if (held_vld) chk("hold_stable", {31'b0, out_valid, got}, {31'b0, 1'b1, held});
    held_vld = out_valid & !out_ready;
    held = got;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(s, ea, eb, p));
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_spurious_out actual=0x%0h required=no output", got);
      end else chk("sb_out", {30'b0, got}, {30'b0, exp_q.pop_front()});
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = v.s; in_exp_a = v.ea; in_exp_b = v.eb; in_prod = v.p;
    out_ready = 1'b1;
    #1;
    chk($sformatf("tbl%0d_in_ready", idx), {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("tbl%0d_valid_c1", idx), {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk($sformatf("tbl%0d_valid_c2", idx), {63'b0, out_valid}, 64'd1);
    chk($sformatf("tbl%0d_result", idx), {30'b0, out_ovf, out_unf, out_result},
        {30'b0, v.ovf, v.unf, v.res});
  endtask

  logic        bp_s[4];
  logic [7:0]  bp_a[4];
  logic [7:0]  bp_b[4];
  logic [47:0] bp_p[4];

  initial begin
    logic [31:0] tie_odd, carry_res;
    logic        v;
    int          ix;
`ifdef FP_MUL_ROUND_RNE_EN
    tie_odd = 32'h40000002;
    carry_res = 32'h40000000;
`else
    tie_odd = 32'h40000001;
    carry_res = 32'h3FFFFFFF;
`endif
    tbl[0]  = '{1'b0, 8'd127, 8'd128, 48'h600000000000, 32'h40400000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'd127, 8'd127, 48'h800001800000, tie_odd,      1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'd127, 8'd127, 48'h800000800000, 32'h40000000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'd254, 8'd254, 48'h400000000000, 32'hFF800000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'd1,   8'd1,   48'h400000000000, 32'h00000000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'd0,   8'd130, 48'h400000000000, 32'h80000000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'd255, 8'd0,   48'h400000000000, 32'h7F800000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'd255, 8'd100, 48'h600000000000, 32'hFF800000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'd127, 8'd127, 48'h7FFFFFC00000, carry_res,    1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'd100, 8'd100, 48'h000000000000, 32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'd200, 8'd181, 48'h400000000000, 32'h7F000000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'd200, 8'd182, 48'h400000000000, 32'h7F800000, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'd64,  8'd64,  48'h400000000000, 32'h00800000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'd64,  8'd63,  48'h400000000000, 32'h80000000, 1'b0, 1'b1};

    #12;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_result", {32'b0, out_result}, 64'd0);
    chk("rst_flags", {62'b0, out_ovf, out_unf}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    for (int i = 0; i < 14; i++) apply_vec(tbl[i], i);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom()), gen_exp(), gen_exp(), gen_prod(),
            $urandom_range(0, 2) != 0);
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("rand_drain_empty", 64'(exp_q.size()), 64'd0);

    // Four back-to-back beats against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      bp_s[i] = 1'($urandom());
      bp_a[i] = 8'($urandom_range(1, 254));
      bp_b[i] = 8'($urandom_range(1, 254));
      bp_p[i] = gen_prod();
    end
    acc_cnt = 0;
    out_cnt = 0;
    for (int c = 0; c < 30 && out_cnt < 4; c++) begin
      v = (acc_cnt < 4);
      ix = (acc_cnt < 4) ? acc_cnt : 0;
      cycle(v, bp_s[ix], bp_a[ix], bp_b[ix], bp_p[ix], c >= 5);
      if (c == 2) chk("bp_accepts_before_stall", 64'(acc_cnt), 64'd2);
      if (c >= 2 && c < 5) begin
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
        chk("bp_first_result", {32'b0, out_result}, {32'b0, model(bp_s[0], bp_a[0], bp_b[0], bp_p[0])});
      end
    end
    chk("bp_out_count", 64'(out_cnt), 64'd4);
    chk("bp_accept_count", 64'(acc_cnt), 64'd4);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Reset with two beats in flight
    cycle(1'b1, 1'b0, 8'd127, 8'd128, 48'h600000000000, 1'b0);
    cycle(1'b1, 1'b1, 8'd127, 8'd127, 48'h800000800000, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_out_valid", {63'b0, out_valid}, 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_out_result", {32'b0, out_result}, 64'd0);
    exp_q.delete();
    held_vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("postrst_idle", {63'b0, out_valid}, 64'd0);
    end
    cycle(1'b1, 1'b1, 8'd127, 8'd128, 48'h600000000000, 1'b1);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("postrst_one_result", 64'(out_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
